// File: rtl/knowles_sum_stage_if.sv
// Bus interface for knowles_sum_stage.
// Groups the upstream prefix-tree result handshake (in_*) and the downstream
// result handshake (out_*). slave = the sum stage, master = producer/consumer side.
interface knowles_sum_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_p;
  logic [WIDTH-1:0] in_g;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport slave (
    input  in_valid, in_p, in_g, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport master (
    output in_valid, in_p, in_g, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/knowles_sum_stage.sv
// Registered sum stage after a Knowles prefix tree.
// Forms sum/cout/ovf/zero from the half-sum bits and group generates, then
// buffers results in a 2-entry skid buffer (main M drives out_*, skid S).
// Ports: clk, rst_n (async, active-low), bus (knowles_sum_stage_if.slave):
//   in_valid/in_ready/in_p/in_g/in_cin  upstream prefix result handshake
//   out_valid/out_ready/out_sum/out_cout/out_ovf/out_zero  result handshake
module knowles_sum_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  knowles_sum_stage_if.slave   bus
);
  // Entry layout: {zero, ovf, cout, sum}
  localparam int unsigned EW = WIDTH + 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   m_q, m_d;
  logic [EW-1:0]   s_q, s_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [WIDTH-1:0] sum_c;
  logic [EW-1:0]    new_c;
  logic             in_xfer_c;
  logic             out_xfer_c;

  // Sum post-processing: carry into bit i is g[i-1], cin for bit 0.
  always_comb begin
    sum_c = bus.in_p ^ {bus.in_g[WIDTH-2:0], bus.in_cin};
    new_c = {~|sum_c,
             bus.in_g[WIDTH-1] ^ bus.in_g[WIDTH-2],
             bus.in_g[WIDTH-1],
             sum_c};
  end

  assign in_xfer_c  = bus.in_valid & in_ready_q;
  assign out_xfer_c = out_valid_q & bus.out_ready;

  // State and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state on buffer occupancy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (in_xfer_c) state_d = ONE;
      ONE: begin
        if (in_xfer_c && !out_xfer_c)      state_d = FULL;
        else if (!in_xfer_c && out_xfer_c) state_d = EMPTY;
      end
      FULL:  if (out_xfer_c) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Buffer loads and registered handshake outputs.
  always_comb begin
    m_d         = m_q;
    s_d         = s_q;
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    unique case (state_q)
      EMPTY: if (in_xfer_c) m_d = new_c;
      ONE: begin
        if (in_xfer_c && out_xfer_c) m_d = new_c;
        else if (in_xfer_c)          s_d = new_c;
      end
      FULL:  if (out_xfer_c) m_d = s_q;
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = m_q[WIDTH-1:0];
  assign bus.out_cout  = m_q[WIDTH];
  assign bus.out_ovf   = m_q[WIDTH+1];
  assign bus.out_zero  = m_q[WIDTH+2];
endmodule

// File: tb/tb_knowles_sum_stage.sv
// Testbench for knowles_sum_stage: directed corner cases plus random traffic
// against an operand-level model (a+b+cin) with a 2-deep FIFO scoreboard.
module tb_knowles_sum_stage;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  knowles_sum_stage_if #(.WIDTH(WIDTH)) bus_if ();
  knowles_sum_stage #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [35:0] exp_q[$];  // {zero, ovf, cout, sum}, head = presented result

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected result straight from integer addition.
  function automatic logic [35:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic cin);
    logic [32:0] s;
    logic        ovf;
    s   = {1'b0, a} + {1'b0, b} + 33'(cin);
    ovf = (a[31] == b[31]) && (s[31] != a[31]);
    return {s[31:0] == 32'd0, ovf, s[32], s[31:0]};
  endfunction

  // Carry out of each bit position, obtained from truncated additions.
  function automatic logic [31:0] gen_vec(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
    logic [31:0] g;
    logic [32:0] mask;
    logic [32:0] part;
    for (int i = 0; i < 32; i++) begin
      mask = (33'd1 << (i + 1)) - 33'd1;
      part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 33'(cin);
      g[i] = part[i+1];
    end
    return g;
  endfunction

  // One clock: drive inputs, advance the model, then check at the falling edge.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic ordy, input string tag);
    bit in_acc;
    bit out_acc;
    bus_if.in_valid  = iv;
    bus_if.in_p      = iv ? (a ^ b) : $urandom;
    bus_if.in_g      = iv ? gen_vec(a, b, cin) : $urandom;
    bus_if.in_cin    = iv ? cin : 1'($urandom);
    bus_if.out_ready = ordy;
    in_acc  = iv && (exp_q.size() < 2);
    out_acc = ordy && (exp_q.size() > 0);
    if (out_acc) void'(exp_q.pop_front());
    if (in_acc)  exp_q.push_back(ref_result(a, b, cin));
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s.in_ready", tag), 64'(bus_if.in_ready), 64'(exp_q.size() < 2));
    check($sformatf("%s.out_valid", tag), 64'(bus_if.out_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0)
      check($sformatf("%s.data", tag),
            64'({bus_if.out_zero, bus_if.out_ovf, bus_if.out_cout, bus_if.out_sum}),
            64'(exp_q[0]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s.out_valid", tag), 64'(bus_if.out_valid), 64'd0);
    check($sformatf("%s.in_ready", tag), 64'(bus_if.in_ready), 64'd1);
    check($sformatf("%s.out_fields", tag),
          64'({bus_if.out_zero, bus_if.out_ovf, bus_if.out_cout, bus_if.out_sum}), 64'd0);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_p      = '0;
    bus_if.in_g      = '0;
    bus_if.in_cin    = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed corner cases, out_ready held high.
    cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, "wrap");
    cycle(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, "ovf");
    cycle(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, "cin_only");
    cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, "cin_wrap");
    cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, "neg_ovf");
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "drain");

    // Stall: four offers, only two fit; then drain in order.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'b0, $sformatf("stall%0d", i));
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, $sformatf("unstall%0d", i));

    // Back-to-back random stream.
    for (int i = 0; i < 100; i++)
      cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'b1, $sformatf("b2b%0d", i));
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "b2b_drain");

    // Random valid/ready mix exercising the skid path.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom),
            1'($urandom_range(0, 2) != 0), $sformatf("mix%0d", i));

    // Fill, then reset asynchronously mid-cycle.
    cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, "fill0");
    cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0, "fill1");
    bus_if.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "post_rst_idle");
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "post_rst_idle2");
    cycle(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, "post_rst_xfer");
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "post_rst_drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
